mac_seq_ctrl: RTL and testbench

Sequencer that runs a 4-bit × 4-bit multiply-accumulate datapath over a burst of operand pairs to compute a dot product. It loads an initial accumulator value, accepts `len` operand pairs over a valid/ready stream, accumulates each product, and then presents the final sum on a valid/ready result port. It sits between an operand source (FIFO or register file reader) and the consumer of the dot-product result, and owns the accumulator register and the multiplier.

---
 rtl/mac_seq_ctrl_if.sv | 30 +++
 rtl/mac_seq_ctrl.sv | 86 ++++++++
 tb/tb_mac_seq_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream, result stream and burst control bundle for mac_seq_ctrl.
// The master side drives operands and control; the slave side is the sequencer.
interface mac_seq_ctrl_if #(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned LEN_W = 5
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [ACC_W-1:0] acc_init;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic             overflow;
    logic             busy;

    modport master (
        output start, len, acc_init, clear, in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, busy
    );

    modport slave (
        input  start, len, acc_init, clear, in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow, busy
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: loads an initial accumulator, accumulates len 4x4 products
// from a valid/ready stream, then holds the sum on a valid/ready result port.
module mac_seq_ctrl #(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned LEN_W = 5
) (
    input logic          clk,
    input logic          rst,
    mac_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       prod;
    logic [ACC_W:0]   sum;

    assign prod = {4'b0, bus.a} * {4'b0, bus.b};
    // Extra top bit of sum is the carry-out that feeds the sticky overflow flag.
    assign sum  = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start) state_d = (bus.len == '0) ? StDone : StRun;
            StRun:  if (bus.in_valid && cnt_q == LEN_W'(1)) state_d = StDone;
            StDone: if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.clear) state_d = StIdle;
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (bus.clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (state_q == StIdle && bus.start) begin
            acc_d = bus.acc_init;
            cnt_d = bus.len;
            ovf_d = 1'b0;
        end else if (state_q == StRun && bus.in_valid) begin
            acc_d = sum[ACC_W-1:0];
            cnt_d = cnt_q - LEN_W'(1);
            ovf_d = ovf_q | sum[ACC_W];
        end
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            StRun: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
            end
            StDone: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
        bus.result   = acc_q;
        bus.overflow = ovf_q;
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with hand-computed dot products.
module tb_mac_seq_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mac_seq_ctrl_if #(.ACC_W(12), .LEN_W(5)) bus ();

    mac_seq_ctrl #(.ACC_W(12), .LEN_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [11:0] init, input logic [4:0] n);
        bus.start    = 1'b1;
        bus.acc_init = init;
        bus.len      = n;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_pair(input logic [3:0] av, input logic [3:0] bv);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", bus.busy); end
        checks++; if (bus.result !== 12'd0) begin errors++; $display("FAIL rst_result got %0d want 0", bus.result); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0b want 0", bus.overflow); end
    endtask

    task automatic test_basic();
        logic [3:0] av [4] = '{4'd3, 4'd11, 4'd7, 4'd3};
        logic [3:0] bv [4] = '{4'd10, 4'd10, 4'd2, 4'd2};
        start_burst(12'd10, 5'd4);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %0b want 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", bus.busy); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid pair %0d got %0b want 0", i, bus.out_valid); end
            bus.a = av[i]; bus.b = bv[i]; bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %0b want 1", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_done_in_ready got %0b want 0", bus.in_ready); end
        checks++; if (bus.result !== 12'd170) begin errors++; $display("FAIL basic_result got %0d want 170", bus.result); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got %0b want 0", bus.overflow); end
        handshake();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %0b want 0", bus.busy); end
        checks++; if (bus.result !== 12'd170) begin errors++; $display("FAIL basic_hold_result got %0d want 170", bus.result); end
    endtask

    task automatic test_overflow();
        start_burst(12'd4000, 5'd1);
        send_pair(4'd15, 4'd15);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_out_valid got %0b want 1", bus.out_valid); end
        checks++; if (bus.result !== 12'd129) begin errors++; $display("FAIL ovf_result got %0d want 129", bus.result); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", bus.overflow); end
        handshake();
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold_idle got %0b want 1", bus.overflow); end
        // Back-to-back: new start on the first idle cycle after the handshake.
        start_burst(12'd0, 5'd1);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %0b want 1", bus.in_ready); end
        send_pair(4'd1, 4'd1);
        checks++; if (bus.result !== 12'd1) begin errors++; $display("FAIL ovf_fresh_result got %0d want 1", bus.result); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_fresh_flag got %0b want 0", bus.overflow); end
        handshake();
    endtask

    task automatic test_zero_len();
        start_burst(12'd55, 5'd0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL zero_out_valid got %0b want 1", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready got %0b want 0", bus.in_ready); end
        checks++; if (bus.result !== 12'd55) begin errors++; $display("FAIL zero_result got %0d want 55", bus.result); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL zero_overflow got %0b want 0", bus.overflow); end
        handshake();
    endtask

    task automatic test_bubbles();
        logic vseq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        start_burst(12'd0, 5'd3);
        bus.a = 4'd2;
        bus.b = 4'd3;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready step %0d got %0b want 1", i, bus.in_ready); end
            bus.in_valid = vseq[i];
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bubble_out_valid got %0b want 1", bus.out_valid); end
        checks++; if (bus.result !== 12'd18) begin errors++; $display("FAIL bubble_result got %0d want 18", bus.result); end
        bus.out_ready = 1'b0;
        bus.start     = 1'b1;
        bus.acc_init  = 12'd99;
        bus.len       = 5'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.result !== 12'd18) begin errors++; $display("FAIL stall_result cycle %0d got %0d want 18", i, bus.result); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid cycle %0d got %0b want 1", i, bus.out_valid); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_busy cycle %0d got %0b want 1", i, bus.busy); end
        end
        bus.start = 1'b0;
        handshake();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bubble_idle_busy got %0b want 0", bus.busy); end
        checks++; if (bus.result !== 12'd18) begin errors++; $display("FAIL bubble_idle_result got %0d want 18", bus.result); end
    endtask

    task automatic test_clear();
        start_burst(12'd4095, 5'd4);
        send_pair(4'd1, 4'd1);
        send_pair(4'd2, 4'd2);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_overflow got %0b want 1", bus.overflow); end
        // Clear wins over a concurrent operand acceptance.
        bus.clear = 1'b1; bus.a = 4'd3; bus.b = 4'd3; bus.in_valid = 1'b1;
        tick();
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %0b want 0", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %0b want 0", bus.busy); end
        checks++; if (bus.result !== 12'd0) begin errors++; $display("FAIL clr_result got %0d want 0", bus.result); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %0b want 0", bus.overflow); end
        start_burst(12'd5, 5'd2);
        send_pair(4'd2, 4'd2);
        send_pair(4'd3, 4'd3);
        checks++; if (bus.result !== 12'd18) begin errors++; $display("FAIL clr_after_result got %0d want 18", bus.result); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clr_after_valid got %0b want 1", bus.out_valid); end
        // Clear wins over a result handshake.
        bus.clear = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.clear = 1'b0; bus.out_ready = 1'b0;
        checks++; if (bus.result !== 12'd0) begin errors++; $display("FAIL clr_done_result got %0d want 0", bus.result); end
        // Clear wins over start in IDLE.
        bus.clear = 1'b1;
        start_burst(12'd77, 5'd1);
        bus.clear = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_start_busy got %0b want 0", bus.busy); end
        checks++; if (bus.result !== 12'd0) begin errors++; $display("FAIL clr_start_result got %0d want 0", bus.result); end
    endtask

    task automatic test_reset_mid();
        start_burst(12'd4095, 5'd4);
        send_pair(4'd1, 4'd1);
        send_pair(4'd2, 4'd2);
        rst = 1'b1; bus.clear = 1'b1; bus.in_valid = 1'b1;
        tick();
        rst = 1'b0; bus.clear = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstm_in_ready got %0b want 0", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstm_busy got %0b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstm_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.result !== 12'd0) begin errors++; $display("FAIL rstm_result got %0d want 0", bus.result); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rstm_overflow got %0b want 0", bus.overflow); end
        start_burst(12'd100, 5'd2);
        send_pair(4'd15, 4'd1);
        send_pair(4'd4, 4'd5);
        checks++; if (bus.result !== 12'd135) begin errors++; $display("FAIL rstm_after_result got %0d want 135", bus.result); end
        handshake();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.acc_init  = '0;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_overflow();
        test_zero_len();
        test_bubbles();
        test_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
